// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch unit: issues one word address at a time,
// captures the returned word and holds it until the consumer takes it or a redirect lands.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        imem_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

  state_t      state_r, state_s;
  logic        kill_r, kill_s;
  logic [31:0] pend_pc_r, pend_pc_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [31:0] addr_s, out_s, pc_s;
  logic        valid_s, err_s;

  logic [31:0] redir_tgt_s;
  logic [31:0] exit_tgt_s;
  logic        exit_kill_s;
  logic        exit_same_s;

  // Outcome of completing a fetch (WAIT exit or silent-memory fallback).
  // A redirect arriving in the same cycle overrides any pending target.
  always_comb begin
    redir_tgt_s = align_pc(redirect_pc);
    exit_kill_s = kill_r | redirect_valid;
    if (redirect_valid) begin
      exit_tgt_s = redir_tgt_s;
    end else begin
      exit_tgt_s = pend_pc_r;
    end
    exit_same_s = (exit_tgt_s == imem_addr);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s   = state_r;
    kill_s    = kill_r;
    pend_pc_s = pend_pc_r;
    cnt_s     = cnt_r;
    addr_s    = imem_addr;
    out_s     = inst_out;
    pc_s      = inst_pc;
    valid_s   = inst_valid;
    err_s     = fetch_err;

    case (state_r)
      ISSUE: begin
        if (imem_stall) begin
          state_s = WAIT;
          if (redirect_valid) begin
            pend_pc_s = redir_tgt_s;
            kill_s    = 1'b1;
          end else begin
            kill_s = kill_r;
          end
        end else if (cnt_r == CNT_LAST) begin
          // Memory never answered: take whatever it drives and flag it.
          err_s  = 1'b1;
          kill_s = 1'b0;
          if (exit_kill_s && !exit_same_s) begin
            addr_s  = exit_tgt_s;
            valid_s = 1'b0;
            cnt_s   = 4'd0;
            state_s = ISSUE;
          end else begin
            out_s   = imem_data;
            pc_s    = exit_kill_s ? exit_tgt_s : imem_addr;
            valid_s = 1'b1;
            state_s = VALID;
          end
        end else begin
          cnt_s = cnt_r + 4'd1;
          if (redirect_valid) begin
            pend_pc_s = redir_tgt_s;
            kill_s    = 1'b1;
          end else begin
            kill_s = kill_r;
          end
        end
      end

      WAIT: begin
        kill_s = 1'b0;
        if (exit_kill_s && !exit_same_s) begin
          addr_s  = exit_tgt_s;
          valid_s = 1'b0;
          cnt_s   = 4'd0;
          state_s = ISSUE;
        end else begin
          // Same target as the address just fetched: reuse the returned word.
          out_s   = imem_data;
          pc_s    = exit_kill_s ? exit_tgt_s : imem_addr;
          valid_s = 1'b1;
          state_s = VALID;
        end
      end

      VALID: begin
        if (redirect_valid) begin
          if (redir_tgt_s == imem_addr) begin
            out_s   = imem_data;
            pc_s    = redir_tgt_s;
            valid_s = 1'b1;
            state_s = VALID;
          end else begin
            addr_s  = redir_tgt_s;
            valid_s = 1'b0;
            cnt_s   = 4'd0;
            state_s = ISSUE;
          end
        end else if (inst_ready) begin
          addr_s  = imem_addr + 32'd4;
          valid_s = 1'b0;
          cnt_s   = 4'd0;
          state_s = ISSUE;
        end else begin
          state_s = VALID;
        end
      end

      default: begin
        state_s = ISSUE;
        kill_s  = 1'b0;
        cnt_s   = 4'd0;
        valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ISSUE;
      kill_r     <= 1'b0;
      pend_pc_r  <= 32'h0000_0000;
      cnt_r      <= 4'd0;
      imem_addr  <= RESET_PC;
      inst_pc    <= RESET_PC;
      inst_out   <= 32'h0000_0000;
      inst_valid <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      state_r    <= state_s;
      kill_r     <= kill_s;
      pend_pc_r  <= pend_pc_s;
      cnt_r      <= cnt_s;
      imem_addr  <= addr_s;
      inst_pc    <= pc_s;
      inst_out   <= out_s;
      inst_valid <= valid_s;
      fetch_err  <= err_s;
    end
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h00000000, word-aligned address of the first fetch after reset.
REQ-002 Parameter TIMEOUT, 4, ISSUE-state cycles without imem_stall before the silent-memory fallback fires; legal range 3..15.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 imem_addr  output  32  registered byte address presented to the instruction memory.
REQ-006 imem_data  input  32  instruction word from the memory, valid in the cycle after imem_stall falls.
REQ-007 imem_stall  input  1  memory busy flag; one-cycle high pulse per fetch of a changed address.
REQ-008 redirect_valid  input  1  branch/jump request, one cycle.
REQ-009 redirect_pc  input  32  redirect target; bits [1:0] ignored and forced to 0.
REQ-010 inst_valid  output  1  inst_out/inst_pc hold a deliverable instruction.
REQ-011 inst_ready  input  1  consumer accepts; transfer = inst_valid & inst_ready & !redirect_valid.
REQ-012 inst_out  output  32  fetched instruction word.
REQ-013 inst_pc  output  32  address of inst_out.
REQ-014 fetch_err  output  1  sticky flag, set when the silent-memory fallback fires.

Function
REQ-015 The FSM SHALL have exactly three states: ISSUE (waiting for imem_stall high), WAIT (one cycle, capturing data), VALID (holding the instruction).
REQ-016 ISSUE: imem_stall==1 at an edge -> WAIT; otherwise increment the timeout counter.
REQ-017 WAIT: at the next edge, capture imem_data into inst_out and imem_addr into inst_pc, then -> VALID with inst_valid=1; nominal latency is 3 edges from an imem_addr change to inst_valid high.
REQ-018 VALID: on a transfer, imem_addr <= imem_addr+4 (mod 2^32, 32'hFFFFFFFC wraps to 0), inst_valid <= 0, -> ISSUE; otherwise inst_valid, inst_out and inst_pc hold.
REQ-019 imem_addr SHALL change only on leaving VALID, on leaving WAIT with a redirect or kill, and on reset; it SHALL stay stable throughout ISSUE and WAIT so each issued address yields exactly one memory stall pulse.
REQ-020 Redirect in ISSUE: imem_addr unchanged; latch the aligned target into pend_pc and set kill=1; the in-flight fetch completes normally through WAIT.
REQ-021 Leaving WAIT with kill=1 or with redirect_valid=1 (target = redirect_pc, which overrides pend_pc): discard imem_data, clear kill, imem_addr <= target, inst_valid stays 0, -> ISSUE.
REQ-022 Redirect in VALID: inst_valid <= 0, imem_addr <= target, -> ISSUE; the instruction presented in that cycle SHALL NOT count as transferred even if inst_ready=1.
REQ-023 Redirect while kill=1 (in ISSUE): pend_pc SHALL be overwritten; last request wins.
REQ-024 Same-address rule: whenever the new target equals the current imem_addr (REQ-021, REQ-022), the memory does not re-fetch; the block SHALL instead load inst_out <= imem_data and inst_pc <= target, and -> VALID in one edge.
REQ-025 Silent-memory fallback: if the counter reaches TIMEOUT in ISSUE, capture imem_data/imem_addr as in WAIT, -> VALID, set fetch_err; the counter clears on every ISSUE entry.
REQ-026 If redirect_valid and the memory pulse coincide, the redirect SHALL be handled per the current state; no request is dropped.

Reset
REQ-027 On reset: state=ISSUE, imem_addr=RESET_PC, inst_pc=RESET_PC, inst_out=0, inst_valid=0, kill=0, pend_pc=0, counter=0, fetch_err=0.
REQ-028 Reset SHALL override every other input in the same edge, including mid-fetch and mid-redirect.
REQ-029 After a reset where the memory's last address equals RESET_PC, the first instruction SHALL be delivered through REQ-025 with fetch_err=1.

Verification
REQ-030 Reset, RESET_PC=0, memory model with word k = 32'h1000+k, inst_ready=1 -> inst_valid first high 3 edges after reset release; inst_pc sequence 0,4,8 with inst_out 1000,1001,1002.
REQ-031 Redirect to 0x40 in the cycle after imem_addr becomes 8 (ISSUE, stall=0) -> exactly one stall pulse for 8 with no delivery, then imem_addr=0x40, next delivery inst_pc=0x40, inst_out=1010.
REQ-032 inst_valid at pc 0x10 with inst_ready=1 and redirect_valid=1 to 0x10 in the same cycle -> no transfer, no new stall pulse, next edge inst_valid=1, inst_pc=0x10, inst_out=1004.
REQ-033 inst_ready=0 for 5 cycles at pc 0x20 -> inst_valid, inst_out, inst_pc and imem_addr stay stable; no stall pulses.
REQ-034 Memory model never asserts stall, TIMEOUT=4 -> 4 edges in ISSUE, then inst_valid=1 with imem_data captured and fetch_err=1 until reset.
REQ-035 Two redirects (0x80 then 0xC0) on consecutive cycles during ISSUE -> one discarded fetch, then a single fetch and delivery at 0xC0; 0x80 is never presented on imem_addr.
